router_output_arbiter: RTL and testbench

Credit-based round-robin arbiter that shares one quadtree router output link between `NUM_REQ` input-port buffers. It sits inside each root, internal and leaf node, once per output direction. It selects one requesting input per cycle and holds the selection for the whole of a multi-flit packet. It forwards the selected flit onto a registered output link and tracks downstream buffer space through returned credits.

---
 rtl/router_output_arbiter.sv | 156 +++++++++++++++
 tb/tb_router_output_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_output_arbiter.sv
// ---------------------------------------------------------------------------
// router_output_arbiter
//
// Shares one quadtree router output link between NUM_REQ input-port buffers.
// A round-robin arbiter picks one requesting buffer per cycle and holds that
// choice until the packet tail has gone out. Downstream buffer space is
// tracked with a credit counter: a flit goes out only while a credit is in
// hand, and each returned credit pulse gives one slot back.
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   req_valid[i]      head flit of input buffer i is valid
//   req_last[i]       head flit of input buffer i is the packet tail
//   req_data          head flits, slice i = [i*FLIT_WIDTH +: FLIT_WIDTH]
//   grant[i]          one-hot, combinational; pops input buffer i this cycle
//   out_data_valid    registered flit-valid toward the downstream node
//   out_data          registered flit toward the downstream node
//   downstream_credit one-cycle pulse, downstream freed one buffer slot
//   credit_err        sticky; a credit came back while the counter was full
// ---------------------------------------------------------------------------
module router_output_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FLIT_WIDTH   = 32,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          out_data_valid,
    output logic [FLIT_WIDTH-1:0]         out_data,
    input  logic                          downstream_credit,
    output logic                          credit_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_DEPTH);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       owner;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [PTR_W-1:0]       sel;
    logic                   send;
    logic                   credit_err_q;
    logic                   vld_p1;
    logic [FLIT_WIDTH-1:0]  flit_p1;

    // Requester index base+step, wrapped into 0..NUM_REQ-1.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base,
                                                  input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // Credit counter update, saturating at CREDIT_DEPTH. A send and a
    // credit in the same cycle cancel. Underflow cannot happen because
    // send is never raised at zero.
    function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] c,
                                                     input logic            snd,
                                                     input logic            crd);
        if (snd && !crd) begin
            return c - CNT_W'(1);
        end
        if (!snd && crd && (c != CNT_MAX)) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    // Stage p0: arbitration on the current head flits.
    always_comb begin
        logic [PTR_W-1:0] cand;
        grant = '0;
        sel   = '0;
        send  = 1'b0;
        cand  = '0;
        // A credit arriving this cycle is not counted yet, so cnt == 0
        // blocks the grant even when downstream_credit is high.
        if (!rst && (cnt != '0)) begin
            if (state == LOCKED) begin
                if (req_valid[owner]) begin
                    send = 1'b1;
                    sel  = owner;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = wrap_inc(ptr, k);
                    if (!send && req_valid[cand]) begin
                        send = 1'b1;
                        sel  = cand;
                    end
                end
            end
        end
        if (send) begin
            grant[sel] = 1'b1;
        end
    end

    assign cnt_next = credit_next(cnt, send, downstream_credit);

    // Stage p1: registered output link, credit counter and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= CNT_MAX;
            credit_err_q <= 1'b0;
            vld_p1       <= 1'b0;
            flit_p1      <= '0;
        end else begin
            vld_p1 <= send;
            if (send) begin
                flit_p1 <= req_data[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];
            end

            cnt <= cnt_next;
            // A send in the same cycle consumes the slot the credit frees,
            // so only a credit at a full counter with no send is an error.
            if (downstream_credit && !send && (cnt == CNT_MAX)) begin
                credit_err_q <= 1'b1;
            end

            if (send) begin
                if (req_last[sel]) begin
                    state <= IDLE;
                    ptr   <= wrap_inc(sel, 1);
                end else begin
                    state <= LOCKED;
                    owner <= sel;
                end
            end
        end
    end

    assign out_data_valid = vld_p1;
    assign out_data       = flit_p1;
    assign credit_err     = credit_err_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_output_arbiter
//
// Randomized and directed stimulus for router_output_arbiter. A packet-level
// reference model (credit count, lock owner, round-robin preference) predicts
// each cycle's grant; granted flits are queued with their grant cycle and a
// separate monitor pops and compares them when the output link shows valid.
// ---------------------------------------------------------------------------
module tb_router_output_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic           out_data_valid;
    logic [W-1:0]   out_data;
    logic           downstream_credit;
    logic           credit_err;

    always #5 clk = ~clk;

    router_output_arbiter #(
        .NUM_REQ      (N),
        .FLIT_WIDTH   (W),
        .CREDIT_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_last          (req_last),
        .req_data          (req_data),
        .grant             (grant),
        .out_data_valid    (out_data_valid),
        .out_data          (out_data),
        .downstream_credit (downstream_credit),
        .credit_err        (credit_err)
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    logic armed  = 1'b0;

    // Reference model state
    int   m_credits;
    int   m_owner;     // -1 when no packet is in progress
    int   m_rr;        // preferred requester for the next new packet
    logic m_err;

    logic [N-1:0] g_last;

    always @(posedge clk) cycle++;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    function automatic void model_reset();
        m_credits = DEPTH;
        m_owner   = -1;
        m_rr      = 0;
        m_err     = 1'b0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v);
        int j;
        if (m_credits == 0) return -1;
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic cr,
                        input logic r, output logic [N-1:0] g);
        int           pick;
        int           pre;
        logic [N-1:0] g_exp;
        logic [W-1:0] slice [N];
        @(negedge clk);
        if (armed) check("credit_err", credit_err, m_err);
        rst               = r;
        req_valid         = v;
        req_last          = l;
        downstream_credit = cr;
        for (int i = 0; i < N; i++) begin
            slice[i]            = $urandom;
            req_data[i*W +: W]  = slice[i];
        end
        #1;
        pick  = r ? -1 : model_pick(v);
        g_exp = (pick >= 0) ? (N'(1) << pick) : '0;
        check("grant", grant, g_exp);
        g = grant;
        if (r) begin
            model_reset();
        end else begin
            pre = m_credits;
            if (pick >= 0) begin
                exp_q.push_back('{slice[pick], cycle});
                m_credits--;
                if (l[pick]) begin
                    m_owner = -1;
                    m_rr    = (pick + 1) % N;
                end else begin
                    m_owner = pick;
                end
            end
            if (cr) begin
                if (pick < 0 && pre == DEPTH) m_err = 1'b1;
                else m_credits++;
            end
        end
    endtask

    task automatic go(input logic [N-1:0] v, input logic [N-1:0] l, input logic cr);
        step(v, l, cr, 1'b0, g_last);
    endtask

    // Output-link monitor
    always @(negedge clk) begin
        exp_t e;
        if (armed && out_data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_flit: unexpected valid with data %0h, none expected", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_latency", cycle, e.cyc + 1);
            end
        end
    end

    logic [N-1:0] rr_exp  [6];
    logic [N-1:0] lck_exp [5];
    int           sent;
    logic [N-1:0] v_r, l_r;
    logic         cr_r, rst_r;

    initial begin
        rst               = 1'b1;
        req_valid         = '0;
        req_last          = '0;
        req_data          = '0;
        downstream_credit = 1'b0;
        model_reset();
        rr_exp  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        lck_exp = '{4'h2, 4'h0, 4'h2, 4'h2, 4'h4};

        // Reset with every requester valid
        step(4'hF, 4'hF, 1'b0, 1'b1, g_last);
        step(4'hF, 4'hF, 1'b0, 1'b1, g_last);
        @(posedge clk);
        #1;
        armed = 1'b1;
        check("rst_out_valid", out_data_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_credit_err", credit_err, 0);

        // Round-robin with single-flit packets and a credit every cycle
        for (int k = 0; k < 6; k++) begin
            go(4'hF, 4'hF, 1'b1);
            check("rr_order", g_last, rr_exp[k]);
        end

        // Credit exhaustion: requester 2 alone, no credits back
        sent = 0;
        for (int k = 0; k < 6; k++) begin
            go(4'h4, 4'h4, 1'b0);
            sent += $countones(g_last);
        end
        check("exhaust_sent", sent, 4);
        go(4'h4, 4'h4, 1'b1);
        check("credit_same_cycle_no_grant", g_last, 4'h0);
        go(4'h4, 4'h4, 1'b0);
        check("credit_next_cycle_grant", g_last, 4'h4);
        sent = 0;
        for (int k = 0; k < 2; k++) begin
            go(4'h4, 4'h4, 1'b0);
            sent += $countones(g_last);
        end
        check("exhaust_after_one", sent, 0);

        // Send and credit together at cnt 1, then credit alone at cnt 0
        go(4'h0, 4'h0, 1'b1);
        go(4'h4, 4'h4, 1'b1);
        check("cnt1_send_credit", g_last, 4'h4);
        go(4'h4, 4'h4, 1'b0);
        check("cnt1_held", g_last, 4'h4);
        go(4'h4, 4'h4, 1'b1);
        check("cnt0_credit_no_grant", g_last, 4'h0);
        go(4'h4, 4'h4, 1'b0);
        check("cnt0_credit_next", g_last, 4'h4);
        for (int k = 0; k < 4; k++) go(4'h0, 4'h0, 1'b1);

        // Packet lock: requester 1 sends a 3-flit packet while 0 waits
        go(4'h1, 4'h1, 1'b1);
        go(4'h3, 4'h0, 1'b0);
        check("lock_order", g_last, lck_exp[0]);
        go(4'h1, 4'h0, 1'b0);
        check("lock_order", g_last, lck_exp[1]);
        go(4'h3, 4'h0, 1'b0);
        check("lock_order", g_last, lck_exp[2]);
        go(4'h3, 4'h2, 1'b0);
        check("lock_order", g_last, lck_exp[3]);
        go(4'hF, 4'hF, 1'b0);
        check("lock_order", g_last, lck_exp[4]);
        for (int k = 0; k < 4; k++) go(4'h0, 4'h0, 1'b1);

        // Credit error: send plus credit at full is legal, credit alone is not
        go(4'h1, 4'h1, 1'b1);
        @(posedge clk);
        #1;
        check("full_send_credit_no_err", credit_err, 0);
        go(4'h0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        check("credit_err_set", credit_err, 1);
        go(4'h0, 4'h0, 1'b1);
        go(4'h0, 4'h0, 1'b0);
        check("credit_err_sticky", credit_err, 1);
        sent = 0;
        for (int k = 0; k < 6; k++) begin
            go(4'h8, 4'h8, 1'b0);
            sent += $countones(g_last);
        end
        check("saturated_sent", sent, 4);
        step(4'h0, 4'h0, 1'b0, 1'b1, g_last);
        @(posedge clk);
        #1;
        check("rst_clears_err", credit_err, 0);

        // Reset in the middle of a packet clears the lock
        go(4'h8, 4'h0, 1'b0);
        step(4'hF, 4'h0, 1'b0, 1'b1, g_last);
        go(4'h1, 4'h1, 1'b0);
        check("reset_clears_lock", g_last, 4'h1);

        // Randomized traffic with a downstream that returns credits late
        for (int k = 0; k < 3000; k++) begin
            v_r   = N'($urandom);
            l_r   = N'($urandom);
            cr_r  = (m_credits < DEPTH) && ($urandom_range(0, 2) != 0);
            rst_r = ($urandom_range(0, 299) == 0);
            step(v_r, l_r, cr_r, rst_r, g_last);
        end

        for (int k = 0; k < 3; k++) go(4'h0, 4'h0, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
